calc_input_ctrl: RTL and testbench
==================================

Name: calc_input_ctrl

Overview:
- Registered front end for the switch calculator.
- Debounces KEY[1:0], captures two 4-bit operands from SW on a key press, and keeps an add/subtract mode toggle.
- Computes a registered 4-bit result with an overflow flag.
- Feeds the downstream display stage: operands, result, sign and mode go straight to the hex drivers.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a key change is accepted (10 ms at 50 MHz); minimum 2.
- W, 4, operand/result width; only 4 is required to be supported.

Ports:
- MAX10_CLK1_50  in   1  system clock, the single clock domain
- RST            in   1  synchronous reset, active-high
- SW             in   10 slide switches, asynchronous; SW[7:4]=x, SW[3:0]=y
- KEY            in   2  push buttons, active-low, asynchronous; KEY[0]=mode toggle, KEY[1]=capture
- MODE           in   1  1 = two's complement, 0 = unsigned; sampled in COMPUTE
- x_q            out  4  captured operand x
- y_q            out  4  captured operand y
- result         out  4  x_q+y_q or x_q-y_q, modulo 16
- overflow       out  1  result out of range for the current MODE/op
- sub_mode       out  1  0 = add, 1 = subtract
- result_valid   out  1  one-cycle pulse when result/overflow update
- busy           out  1  high in CAPTURE and COMPUTE

Behaviour:
- Clock and reset: one clock, MAX10_CLK1_50. Reset is synchronous and active-high (RST).
- Reset values: all outputs 0; FSM in IDLE; debounce counters 0; debounced key state 1 (released).
- Input synchronisation: KEY and SW each pass through a 2-FF synchroniser before use.
- Debounce (per key):
  - Counter increments while the synced level differs from the stable level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level takes the synced level and the counter clears.
  - A press pulse (1 cycle) fires on a stable 1->0 transition. Release generates no pulse.
- Mode: a KEY[0] press pulse toggles sub_mode in the same edge.
- FSM states: IDLE, CAPTURE, COMPUTE, HOLD.
  - IDLE: KEY[1] pulse -> CAPTURE. KEY[0] pulse only toggles sub_mode.
  - CAPTURE (1 cycle): x_q <= synced SW[7:4], y_q <= synced SW[3:0]; -> COMPUTE.
  - COMPUTE (1 cycle): result and overflow registered from x_q, y_q, sub_mode, MODE; -> HOLD. result_valid is asserted in the cycle after COMPUTE.
  - HOLD: outputs held. KEY[1] pulse -> CAPTURE. KEY[0] pulse -> COMPUTE, recomputing with the stored operands and the new mode.
- Latency: press pulse registered in cycle t gives CAPTURE at t+1, COMPUTE at t+2, result_valid high at t+3.
- Arithmetic:
  - Compute in 5 bits; result = low 4 bits.
  - Unsigned add: overflow = carry out.
  - Unsigned sub: overflow = borrow (x_q < y_q).
  - Signed add: overflow = (x[3]==y[3]) && (r[3]!=x[3]).
  - Signed sub: overflow = (x[3]!=y[3]) && (r[3]!=x[3]).
- Simultaneous KEY[0] and KEY[1] pulses: the toggle is applied, and the capture path proceeds using the new sub_mode.
- Press during CAPTURE/COMPUTE:
  - KEY[1] is ignored.
  - KEY[0] toggles sub_mode; COMPUTE samples the updated value if the toggle lands at or before COMPUTE.
- RST mid-operation: returns to the reset state on the next edge; a pending result_valid is suppressed.
- Bounce shorter than DEBOUNCE_CYCLES produces no pulse and no state change.

Decomposition:
- Shared package calc_pkg:
  - FSM state encoding (2 bits: IDLE=0, CAPTURE=1, COMPUTE=2, HOLD=3)
  - op encodings OP_ADD=0, OP_SUB=1
  - MODE_UNSIGNED=0, MODE_TWOS=1
- Sub-module key_debounce (sync + counter + press pulse, parameter DEBOUNCE_CYCLES), instantiated once per key.
- Arithmetic and FSM live in calc_input_ctrl.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: RST high 2 cycles with KEY=2'b11 -> all outputs 0, busy 0, no result_valid.
- Unsigned add: SW[7:0]=8'h35, MODE=0, KEY[1] held low 10 cycles -> x_q=3, y_q=5, result=8, overflow=0. result_valid pulses exactly once, 3 cycles after the debounced press.
- Signed add overflow: SW=8'h76, MODE=1, capture -> result=4'hD, overflow=1.
- Mode toggle in HOLD: then KEY[0] press -> sub_mode=1, result=4'h1, overflow=0, new result_valid pulse, operands unchanged.
- Unsigned borrow: SW=8'h25, MODE=0, sub_mode=1, capture -> result=4'hD, overflow=1.
- Bounce and simultaneity:
  - KEY[1] low for 2 cycles then high -> no capture, busy stays 0.
  - Both keys pressed in the same cycle from add mode -> sub_mode=1, and the captured result is the difference.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the switch-calculator front end.
//   state_t      FSM state encoding (IDLE=0, CAPTURE=1, COMPUTE=2, HOLD=3)
//   OP_ADD/SUB   operation encoding carried by sub_mode
//   MODE_*       number interpretation selected by the MODE input
//   calc_alu     4-bit add/sub with overflow for either interpretation
package calc_pkg;

  localparam int CALC_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  localparam logic OP_ADD        = 1'b0;
  localparam logic OP_SUB        = 1'b1;
  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_TWOS     = 1'b1;

  typedef struct packed {
    logic [CALC_W-1:0] result;
    logic              overflow;
  } calc_res_t;

  // The 5-bit intermediate gives carry (add) or borrow (sub) in bit 4,
  // which is exactly the unsigned overflow in both cases.
  function automatic calc_res_t calc_alu(input logic [CALC_W-1:0] x,
                                         input logic [CALC_W-1:0] y,
                                         input logic              op,
                                         input logic              mode);
    logic [CALC_W:0] s;
    calc_res_t       r;
    if (op == OP_SUB) s = {1'b0, x} - {1'b0, y};
    else              s = {1'b0, x} + {1'b0, y};
    r.result = s[CALC_W-1:0];
    if (mode == MODE_TWOS) begin
      if (op == OP_SUB)
        r.overflow = (x[CALC_W-1] != y[CALC_W-1]) && (s[CALC_W-1] != x[CALC_W-1]);
      else
        r.overflow = (x[CALC_W-1] == y[CALC_W-1]) && (s[CALC_W-1] != x[CALC_W-1]);
    end else begin
      r.overflow = s[CALC_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises one active-low push button, filters bounce and
// emits a one-cycle pulse on each accepted press (stable 1->0).
//   i_clk    system clock
//   i_rst    synchronous reset, active-high
//   i_key    raw asynchronous button level (0 = pressed)
//   o_press  one-cycle press pulse; releases produce nothing
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_press
);

  localparam int              CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_meta  <= i_key;
      r_sync  <= r_meta;
      r_press <= 1'b0;
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == TC) begin
        // Level has differed for DEBOUNCE_CYCLES consecutive cycles.
        r_stable <= r_sync;
        r_cnt    <= '0;
        r_press  <= r_stable & ~r_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/calc_input_ctrl.sv
// calc_input_ctrl: registered front end of the switch calculator.
// Debounces the two keys, captures operands from the switches, keeps the
// add/subtract toggle and produces a registered result with overflow.
//   MAX10_CLK1_50  system clock
//   RST            synchronous reset, active-high
//   SW[7:4]/[3:0]  operand x / operand y (asynchronous)
//   KEY[0]/KEY[1]  mode toggle / capture, active-low (asynchronous)
//   MODE           1 = two's complement, 0 = unsigned
//   x_q, y_q       captured operands
//   result         x_q +/- y_q modulo 16, overflow for current MODE/op
//   sub_mode       0 = add, 1 = subtract
//   result_valid   one-cycle pulse when result/overflow update
//   busy           high in CAPTURE and COMPUTE
//
// state   | meaning
// IDLE    | no operands captured yet, waiting for capture key
// CAPTURE | load x_q/y_q from synchronised switches
// COMPUTE | register result and overflow
// HOLD    | result displayed; capture recaptures, toggle recomputes
module calc_input_ctrl
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int W               = 4
) (
  input  logic         MAX10_CLK1_50,
  input  logic         RST,
  input  logic [9:0]   SW,
  input  logic [1:0]   KEY,
  input  logic         MODE,
  output logic [W-1:0] x_q,
  output logic [W-1:0] y_q,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         sub_mode,
  output logic         result_valid,
  output logic         busy
);

  state_t    r_state;
  state_t    w_next;
  logic      w_tog_press;
  logic      w_cap_press;
  logic      w_capture_en;
  logic      w_compute_en;
  logic      w_sub_next;
  logic [7:0] r_sw_meta;
  logic [7:0] r_sw_sync;
  logic [W-1:0] r_x;
  logic [W-1:0] r_y;
  logic [W-1:0] r_result;
  logic      r_overflow;
  logic      r_sub;
  logic      r_valid;
  calc_res_t w_alu;
  logic      w_unused_sw;

  assign w_unused_sw = ^SW[9:8];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
    .i_clk   (MAX10_CLK1_50),
    .i_rst   (RST),
    .i_key   (KEY[0]),
    .o_press (w_tog_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_capture (
    .i_clk   (MAX10_CLK1_50),
    .i_rst   (RST),
    .i_key   (KEY[1]),
    .o_press (w_cap_press)
  );

  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= SW[7:0];
      r_sw_sync <= r_sw_meta;
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_cap_press) w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_COMPUTE;
      ST_COMPUTE: w_next = ST_HOLD;
      ST_HOLD: begin
        if (w_cap_press)      w_next = ST_CAPTURE;
        else if (w_tog_press) w_next = ST_COMPUTE;
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_capture_en = 1'b0;
    w_compute_en = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_CAPTURE: begin
        w_capture_en = 1'b1;
        busy         = 1'b1;
      end
      ST_COMPUTE: begin
        w_compute_en = 1'b1;
        busy         = 1'b1;
      end
      default: ;
    endcase
  end

  // A toggle landing in the COMPUTE cycle itself is still honoured.
  assign w_sub_next = r_sub ^ w_tog_press;
  assign w_alu      = calc_alu(r_x, r_y, w_sub_next, MODE);

  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      r_x        <= '0;
      r_y        <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_sub      <= OP_ADD;
      r_valid    <= 1'b0;
    end else begin
      r_sub   <= w_sub_next;
      r_valid <= w_compute_en;
      if (w_capture_en) begin
        r_x <= r_sw_sync[7:4];
        r_y <= r_sw_sync[3:0];
      end
      if (w_compute_en) begin
        r_result   <= w_alu.result;
        r_overflow <= w_alu.overflow;
      end
    end
  end

  assign x_q          = r_x;
  assign y_q          = r_y;
  assign result       = r_result;
  assign overflow     = r_overflow;
  assign sub_mode     = r_sub;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_calc_input_ctrl.sv
module tb_calc_input_ctrl;

  logic       clk = 1'b0;
  logic       RST;
  logic [9:0] SW;
  logic [1:0] KEY;
  logic       MODE;
  logic [3:0] x_q, y_q, result;
  logic       overflow, sub_mode, result_valid, busy;

  always #5 clk = ~clk;

  calc_input_ctrl #(.DEBOUNCE_CYCLES(4), .W(4)) dut (
    .MAX10_CLK1_50 (clk),
    .RST           (RST),
    .SW            (SW),
    .KEY           (KEY),
    .MODE          (MODE),
    .x_q           (x_q),
    .y_q           (y_q),
    .result        (result),
    .overflow      (overflow),
    .sub_mode      (sub_mode),
    .result_valid  (result_valid),
    .busy          (busy)
  );

  typedef struct {
    int x;
    int y;
    int res;
    int ov;
    int sub;
    int lat;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   m_sub   = 0;
  int   m_have  = 0;
  int   m_x     = 0;
  int   m_y     = 0;
  int   cyc     = 0;
  int   busy_rise = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference arithmetic from integer ranges rather than bit tricks.
  function automatic void ref_calc(input int x, input int y, input int sub,
                                   input int mode, output int res, output int ov);
    int a, b, t;
    a = x;
    b = y;
    if (mode != 0) begin
      if (a > 7) a -= 16;
      if (b > 7) b -= 16;
    end
    t   = (sub != 0) ? a - b : a + b;
    res = t & 15;
    if (mode != 0) ov = (t < -8 || t > 7) ? 1 : 0;
    else           ov = (t < 0 || t > 15) ? 1 : 0;
  endfunction

  function automatic void push_exp(input int lat);
    exp_t e;
    int   r, o;
    ref_calc(m_x, m_y, m_sub, int'(MODE), r, o);
    e.x = m_x; e.y = m_y; e.res = r; e.ov = o; e.sub = m_sub; e.lat = lat;
    q.push_back(e);
  endfunction

  // Monitor: pops an expectation for every result_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (busy && !prev_busy) busy_rise = cyc;
    prev_busy = busy;
    if (result_valid) begin
      if (q.size() == 0) begin
        chk("valid_without_expect", int'(result_valid), 0);
      end else begin
        e = q.pop_front();
        chk("x_q",      int'(x_q),      e.x);
        chk("y_q",      int'(y_q),      e.y);
        chk("result",   int'(result),   e.res);
        chk("overflow", int'(overflow), e.ov);
        chk("sub_mode", int'(sub_mode), e.sub);
        chk("latency",  cyc - busy_rise, e.lat);
      end
    end
  end

  task automatic do_action(input logic [7:0] sw, input logic mode, input logic [1:0] mask);
    SW   = {2'($urandom_range(0, 3)), sw};
    MODE = mode;
    if (mask[0]) m_sub ^= 1;
    if (mask[1]) begin
      m_x = int'(sw[7:4]);
      m_y = int'(sw[3:0]);
      m_have = 1;
      push_exp(2);
    end else if (mask[0] && m_have != 0) begin
      push_exp(1);
    end
    @(negedge clk);
    KEY = ~mask;
    repeat (10) @(negedge clk);
    KEY = 2'b11;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
    q.delete();
    chk("sub_mode_idle", int'(sub_mode), m_sub);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"},     int'(x_q), 0);
    chk({tag, "_y"},     int'(y_q), 0);
    chk({tag, "_res"},   int'(result), 0);
    chk({tag, "_ov"},    int'(overflow), 0);
    chk({tag, "_sub"},   int'(sub_mode), 0);
    chk({tag, "_valid"}, int'(result_valid), 0);
    chk({tag, "_busy"},  int'(busy), 0);
  endtask

  initial begin
    int busy_seen;
    RST  = 1'b1;
    KEY  = 2'b11;
    SW   = '0;
    MODE = 1'b0;
    repeat (2) @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    do_action(8'h35, 1'b0, 2'b10);   // 3+5 = 8
    do_action(8'h76, 1'b1, 2'b10);   // signed 7+6 overflows
    do_action(8'h76, 1'b1, 2'b01);   // toggle in HOLD: 7-6 = 1
    do_action(8'h25, 1'b0, 2'b10);   // unsigned 2-5 borrows

    // Short bounce on the capture key must be filtered out.
    SW = 10'h0C4;
    @(negedge clk);
    KEY = 2'b01;
    repeat (2) @(negedge clk);
    KEY = 2'b11;
    busy_seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1;
    end
    chk("bounce_busy", busy_seen, 0);
    chk("bounce_x", int'(x_q), m_x);
    chk("bounce_y", int'(y_q), m_y);

    do_action(8'h25, 1'b0, 2'b01);   // back to add mode
    do_action(8'h93, 1'b0, 2'b11);   // both keys: toggle then capture

    for (int n = 0; n < 24; n++)
      do_action(8'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)));

    // Reset while CAPTURE is in progress suppresses the pending result.
    SW = 10'h0E7;
    @(negedge clk);
    KEY = 2'b01;
    for (int i = 0; i < 30 && !busy; i++) @(negedge clk);
    chk("rst_busy_seen", int'(busy), 1);
    RST = 1'b1;
    KEY = 2'b11;
    m_sub  = 0;
    m_have = 0;
    repeat (2) @(negedge clk);
    RST = 1'b0;
    repeat (20) @(negedge clk);
    chk_zero("midrst");
    chk("midrst_queue", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
